decoder4_hold: RTL and testbench

//  Sequential 2**N-way decoder: the inverse of the priority encoder path. Accepts an
//  N-bit index via valid/ready, drives the matching one-hot line (2**N wide), holds it
//  for at least HOLD_CYCLES, and releases it only after downstream acknowledges.

---
 rtl/decoder4_hold_pkg.sv | 17 +
 rtl/decoder4_hold_if.sv | 14 +
 rtl/decoder4_hold_hold_counter.sv | 25 ++
 rtl/decoder4_hold.sv | 67 ++++++
 tb/tb_decoder4_hold.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/decoder4_hold_pkg.sv
// Shared types for decoder4_hold: FSM state encoding and a constant-foldable
// clog2 used to size the hold counter.
package decoder4_hold_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/decoder4_hold_if.sv
// Index-in / one-hot-out handshake bundle for decoder4_hold.
interface decoder4_hold_if #(
  parameter int N = 2
);
  logic [N-1:0]        I;
  logic                I_VALID;
  logic                I_READY;
  logic [(1<<N)-1:0]   O;
  logic                O_VALID;
  logic                O_READY;

  modport master (output I, I_VALID, O_READY, input I_READY, O, O_VALID);
  modport slave  (input I, I_VALID, O_READY, output I_READY, O, O_VALID);
endinterface

// File: rtl/decoder4_hold_hold_counter.sv
// Loadable down-counter that parks at zero; ZERO flags the parked state.
module hold_counter #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] D,
  output logic             ZERO
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (LOAD)               cnt_d = D;
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign ZERO = (cnt_q == '0);
endmodule

// File: rtl/decoder4_hold.sv
// Sequential binary-to-one-hot decoder: latches an accepted index as a one-hot
// word, holds it a minimum number of cycles, then releases on downstream ack.
module decoder4_hold
  import decoder4_hold_pkg::*;
#(
  parameter int N           = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RESETN,
  decoder4_hold_if.slave  bus
);
  localparam int OW    = 1 << N;
  localparam int CNT_W = clog2(HOLD_CYCLES + 1);

  state_e          state_q, state_d;
  logic [OW-1:0]   onehot_q, onehot_d;
  logic            accept;
  logic            cnt_zero;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: if (bus.I_VALID) begin
        accept           = 1'b1;
        state_d          = HOLD;
        onehot_d         = '0;
        onehot_d[bus.I]  = 1'b1;
      end
      // An ack before the minimum hold has elapsed is simply dropped.
      HOLD: if (cnt_zero && bus.O_READY) begin
        state_d  = IDLE;
        onehot_d = '0;
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
    end
  end

  // Loaded with HOLD_CYCLES-1 so that, with ack held high, O is up for
  // exactly HOLD_CYCLES cycles.
  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .CLK    (CLK),
    .RESETN (RESETN),
    .LOAD   (accept),
    .D      (CNT_W'(HOLD_CYCLES - 1)),
    .ZERO   (cnt_zero)
  );

  assign bus.O       = onehot_q;
  assign bus.O_VALID = |onehot_q;
  assign bus.I_READY = (state_q == IDLE);
endmodule

// File: tb/tb_decoder4_hold.sv
// Bench for decoder4_hold: two instances (HOLD_CYCLES=4 and 1) share stimulus and
// are compared every cycle against an age-based reference model.
module tb_decoder4_hold;
  localparam int N = 2;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [1:0] t_i = '0;
  logic       t_v = 1'b0;
  logic       t_r = 1'b0;

  always #5 CLK = ~CLK;

  decoder4_hold_if #(.N(N)) b4 ();
  decoder4_hold_if #(.N(N)) b1 ();

  assign b4.I = t_i;  assign b4.I_VALID = t_v;  assign b4.O_READY = t_r;
  assign b1.I = t_i;  assign b1.I_VALID = t_v;  assign b1.O_READY = t_r;

  decoder4_hold #(.N(N), .HOLD_CYCLES(4)) dut4 (.CLK(CLK), .RESETN(RESETN), .bus(b4));
  decoder4_hold #(.N(N), .HOLD_CYCLES(1)) dut1 (.CLK(CLK), .RESETN(RESETN), .bus(b1));

  int tests = 0;
  int fails = 0;

  // Model: decoded index (-1 = idle) and how many cycles O has been shown.
  int m_idx [2] = '{-1, -1};
  int m_age [2] = '{0, 0};
  int m_hold[2] = '{4, 1};

  typedef struct {
    logic [1:0] idx;
    logic [3:0] exp_o;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] o, eo;
    logic ov, ir;
    for (int k = 0; k < 2; k++) begin
      o  = (k == 0) ? b4.O : b1.O;
      ov = (k == 0) ? b4.O_VALID : b1.O_VALID;
      ir = (k == 0) ? b4.I_READY : b1.I_READY;
      eo = (m_idx[k] < 0) ? 4'd0 : 4'(2 ** m_idx[k]);
      check($sformatf("model_O[h%0d]", m_hold[k]), 32'(o), 32'(eo));
      check($sformatf("model_OV[h%0d]", m_hold[k]), 32'(ov), 32'(m_idx[k] >= 0));
      check($sformatf("model_IR[h%0d]", m_hold[k]), 32'(ir), 32'(m_idx[k] < 0));
      check($sformatf("inv_onehot0[h%0d]", m_hold[k]), 32'($onehot0(o)), 32'd1);
      check($sformatf("inv_ov_or[h%0d]", m_hold[k]), 32'(ov), 32'(|o));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (!RESETN) m_idx[k] = -1;
      else if (m_idx[k] < 0) begin
        if (t_v) begin m_idx[k] = int'(t_i); m_age[k] = 1; end
      end else if (m_age[k] >= m_hold[k] && t_r) m_idx[k] = -1;
      else m_age[k]++;
    end
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle(input int n);
    t_v = 1'b0; t_r = 1'b1;
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic hold_len(input logic [3:0] exp, output int n);
    n = 0;
    while (b4.O == exp && n < 40) begin n++; tick(); end
  endtask

  initial begin
    int n;
    vecs[0] = '{2'd0, 4'b0001};
    vecs[1] = '{2'd1, 4'b0010};
    vecs[2] = '{2'd2, 4'b0100};
    vecs[3] = '{2'd3, 4'b1000};

    // Reset with random inputs
    @(negedge CLK);
    for (int c = 0; c < 3; c++) begin
      t_i = 2'($urandom); t_v = 1'($urandom); t_r = 1'($urandom);
      tick();
      check("rst_O", 32'(b4.O), 32'd0);
      check("rst_IR", 32'(b4.I_READY), 32'd1);
    end
    RESETN = 1'b1;
    idle(2);

    // Decode all indices with ack held high
    foreach (vecs[j]) begin
      t_i = vecs[j].idx; t_v = 1'b1; t_r = 1'b1;
      tick();
      t_v = 1'b0;
      check($sformatf("dec_O[%0d]", j), 32'(b4.O), 32'(vecs[j].exp_o));
      check($sformatf("dec_IR[%0d]", j), 32'(b4.I_READY), 32'd0);
      hold_len(vecs[j].exp_o, n);
      check($sformatf("dec_len[%0d]", j), 32'(n), 32'd4);
      check($sformatf("dec_idle_IR[%0d]", j), 32'(b4.I_READY), 32'd1);
    end
    idle(2);

    // Backpressure: ack low for 10 cycles, release one cycle after it rises
    t_i = 2'd2; t_v = 1'b1; t_r = 1'b0;
    tick();
    t_v = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("bp_held", 32'(b4.O), 32'b0100);
    t_r = 1'b1;
    tick();
    check("bp_release", 32'(b4.O), 32'd0);
    idle(2);

    // Early ack plus new index offered during hold
    t_i = 2'd1; t_v = 1'b1; t_r = 1'b1;
    tick();
    t_i = 2'd3;
    hold_len(4'b0010, n);
    check("early_len", 32'(n), 32'd4);
    check("early_gap", 32'(b4.O), 32'd0);
    tick();
    check("early_next", 32'(b4.O), 32'b1000);
    idle(6);

    // Asynchronous reset in the middle of a hold
    t_i = 2'd3; t_v = 1'b1;
    tick();
    t_v = 1'b0;
    tick();
    #1 RESETN = 1'b0;
    #1;
    m_idx = '{-1, -1};
    check("mid_rst_O", 32'(b4.O), 32'd0);
    check("mid_rst_OV", 32'(b4.O_VALID), 32'd0);
    check("mid_rst_IR", 32'(b4.I_READY), 32'd1);
    tick();
    RESETN = 1'b1;
    t_i = 2'd0; t_v = 1'b1;
    tick();
    check("post_rst_O", 32'(b4.O), 32'b0001);
    idle(6);

    // HOLD_CYCLES=1 instance: single-cycle pulse
    t_i = 2'd2; t_v = 1'b1; t_r = 1'b1;
    tick();
    t_v = 1'b0;
    check("h1_on", 32'(b1.O), 32'b0100);
    tick();
    check("h1_off", 32'(b1.O), 32'd0);
    idle(6);

    // Random traffic against the model, with occasional resets
    for (int c = 0; c < 400; c++) begin
      t_i = 2'($urandom);
      t_v = ($urandom_range(99) < 50);
      t_r = ($urandom_range(99) < 70);
      RESETN = ($urandom_range(99) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
